// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with bypass, zero register, pending-write scoreboard and clear sweep
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         writeaddr,
  input  logic [XLEN-1:0]       writedata,
  input  logic [NREAD*AW-1:0]   readaddr,
  output logic [NREAD*XLEN-1:0] readdata,
  output logic [NREAD-1:0]      rd_pend,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [AW-1:0] idx;
  logic idle, wr_ok, sb_ok;
  assign idle = state == IDLE;
  assign wr_ok = idle && we && !(ZERO_REG != 0 && writeaddr == '0);
  assign sb_ok = idle && sb_set && !(ZERO_REG != 0 && sb_addr == '0);
  // clear FSM: IDLE -> SWEEP on request, back to IDLE after the last index with a one-cycle done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (idle) begin
        if (clr_req) begin
          state <= SWEEP;
          idx <= '0;
          clr_busy <= 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
        if (idx == AW'(NREG - 1)) begin
          state <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end
      end
    end
  end
  // storage and scoreboard: sweep zeroes one entry per cycle, otherwise write clears and issue sets (set wins)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pend <= '0;
    end else if (!idle) begin
      regs[idx] <= '0;
      pend[idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[writeaddr] <= writedata;
        pend[writeaddr] <= 1'b0;
      end
      if (sb_ok) pend[sb_addr] <= 1'b1;
    end
  end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic zr, byp;
    assign ra = readaddr[g*AW +: AW];
    assign zr = ZERO_REG != 0 && ra == '0;
    assign byp = idle && we && writeaddr == ra;
    assign readdata[g*XLEN +: XLEN] = zr ? '0 : byp ? writedata : regs[ra];
    assign rd_pend[g] = !zr && pend[ra] && !byp;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of the default and a wide, non-zero-register configuration
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic we, sb_set, clr_req, busy, done;
  logic [4:0] wa, sa;
  logic [31:0] wd;
  logic [9:0] ra;
  logic [63:0] rd;
  logic [1:0] rp;
  logic web, sbb, clrb, busyb, doneb;
  logic [3:0] wab, sab;
  logic [63:0] wdb;
  logic [11:0] rab;
  logic [191:0] rdb;
  logic [2:0] rpb;
  regfile_sb dut_a (
    .clk(clk), .reset(reset), .we(we), .writeaddr(wa), .writedata(wd),
    .readaddr(ra), .readdata(rd), .rd_pend(rp), .sb_set(sb_set), .sb_addr(sa),
    .clr_req(clr_req), .clr_busy(busy), .clr_done(done)
  );
  regfile_sb #(.XLEN(64), .NREG(16), .NREAD(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .we(web), .writeaddr(wab), .writedata(wdb),
    .readaddr(rab), .readdata(rdb), .rd_pend(rpb), .sb_set(sbb), .sb_addr(sab),
    .clr_req(clrb), .clr_busy(busyb), .clr_done(doneb)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt, dcnt;
    {we, sb_set, clr_req, wa, sa, wd, ra} = '0;
    {web, sbb, clrb, wab, sab, wdb, rab} = '0;
    #12 reset = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0]};
      #1;
      chk("rst_data", {32'h0, rd}, 64'h0);
      chk("rst_pend", {62'h0, rp}, 64'h0);
    end
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd6, 5'd5};
    #1;
    chk("bypass_p0", {32'h0, rd[31:0]}, 64'hDEADBEEF);
    chk("bypass_p1_other", {32'h0, rd[63:32]}, 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("stored_r5", {32'h0, rd[31:0]}, 64'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = {5'd0, 5'd0};
    #1;
    chk("r0_no_bypass", {32'h0, rd[31:0]}, 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("r0_p0", {32'h0, rd[31:0]}, 64'h0);
    chk("r0_p1", {32'h0, rd[63:32]}, 64'h0);
    sb_set = 1'b1; sa = 5'd7; ra = {5'd0, 5'd7};
    #1;
    chk("pend_before_set", {63'h0, rp[0]}, 64'h0);
    tick();
    sb_set = 1'b0;
    #1;
    chk("pend_set_r7", {63'h0, rp[0]}, 64'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    #1;
    chk("pend_bypassed", {63'h0, rp[0]}, 64'h0);
    chk("r7_bypass", {32'h0, rd[31:0]}, 64'h77);
    tick();
    we = 1'b0;
    #1;
    chk("pend_cleared", {63'h0, rp[0]}, 64'h0);
    chk("r7_stored", {32'h0, rd[31:0]}, 64'h77);
    we = 1'b1; wa = 5'd7; wd = 32'h88; sb_set = 1'b1; sa = 5'd7;
    #1;
    chk("same_cyc_pend", {63'h0, rp[0]}, 64'h0);
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    chk("set_wins", {63'h0, rp[0]}, 64'h1);
    chk("r7_88", {32'h0, rd[31:0]}, 64'h88);
    sb_set = 1'b1; sa = 5'd0; ra = {5'd0, 5'd0};
    tick();
    sb_set = 1'b0;
    #1;
    chk("r0_never_pend", {62'h0, rp}, 64'h0);
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = a[4:0]; wd = 32'h1000_0000 | a;
      tick();
    end
    we = 1'b0; sb_set = 1'b1; sa = 5'd3;
    tick();
    sb_set = 1'b0; ra = {5'd31, 5'd3};
    #1;
    chk("fill_r31", {32'h0, rd[63:32]}, 64'h1000001F);
    chk("fill_pend_r3", {63'h0, rp[0]}, 64'h1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0; dcnt = 0;
    while (busy && cnt < 100) begin
      we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
      if (cnt == 10) begin
        we = 1'b1; wa = 5'd2; wd = 32'hCAFE; sb_set = 1'b1; sa = 5'd4; ra = {5'd4, 5'd2};
        #1;
        chk("sweep_no_bypass", {32'h0, rd[31:0]}, 64'h0);
      end
      if (cnt == 11) begin
        ra = {5'd31, 5'd20};
        #1;
        chk("sweep_partial_r31", {32'h0, rd[63:32]}, 64'h1000001F);
      end
      if (cnt == 20) clr_req = 1'b1;
      if (done) dcnt++;
      tick();
      cnt++;
    end
    we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    chk("sweep_len", 64'(cnt), 64'd32);
    chk("done_in_sweep", 64'(dcnt), 64'd0);
    chk("done_pulse", {63'h0, done}, 64'h1);
    tick();
    chk("done_once", {63'h0, done}, 64'h0);
    chk("no_restart", {63'h0, busy}, 64'h0);
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0]};
      #1;
      chk("swept_data", {32'h0, rd}, 64'h0);
      chk("swept_pend", {62'h0, rp}, 64'h0);
    end
    we = 1'b1; wa = 5'd20; wd = 32'h20;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    ra = {5'd31, 5'd20};
    #1;
    chk("abort_r20", {32'h0, rd[31:0]}, 64'h0);
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) dcnt++;
      tick();
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    web = 1'b1; wab = 4'd0; wdb = 64'hA5A5A5A5A5A5A5A5; rab = {4'd0, 4'd0, 4'd0};
    #1;
    chk("b_r0_bypass", rdb[63:0], 64'hA5A5A5A5A5A5A5A5);
    tick();
    wab = 4'd9; wdb = 64'h0123456789ABCDEF;
    tick();
    wab = 4'd15; wdb = 64'hFEDCBA9876543210;
    tick();
    web = 1'b0; rab = {4'd15, 4'd9, 4'd0};
    #1;
    chk("b_p0_r0", rdb[63:0], 64'hA5A5A5A5A5A5A5A5);
    chk("b_p1_r9", rdb[127:64], 64'h0123456789ABCDEF);
    chk("b_p2_r15", rdb[191:128], 64'hFEDCBA9876543210);
    sbb = 1'b1; sab = 4'd0;
    tick();
    sbb = 1'b0;
    #1;
    chk("b_r0_pend", {61'h0, rpb}, 64'h1);
    clrb = 1'b1;
    tick();
    clrb = 1'b0;
    cnt = 0;
    while (busyb && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("b_sweep_len", 64'(cnt), 64'd16);
    chk("b_done", {63'h0, doneb}, 64'h1);
    for (int a = 0; a < 16; a++) begin
      rab = {a[3:0], a[3:0], a[3:0]};
      #1;
      chk("b_swept", {rdb[191:128] | rdb[127:64] | rdb[63:0]}, 64'h0);
      chk("b_swept_pend", {61'h0, rpb}, 64'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
